// File: rtl/spi_slave_bus.sv
// spi_slave_bus: SPI mode-0 responder.
// Oversamples SCLK/CS/SI on i_clk, shifts in BUS_WIDTH-bit words MSB first on
// SCLK rising edges and shifts a reply word out on SO on SCLK falling edges.
// Back-to-back words under one CS assertion are supported. The reply word comes
// from a single valid/ready holding register; an empty register sends TX_IDLE.
// Ports:
//   i_clk, i_rst          system clock (>= 4x SCLK), async active-high reset
//   i_sclk, i_cs, i_si    SPI bus from the master (CS active low, SCLK idle low)
//   o_so                  serial data back to the master
//   i_tx_data/i_tx_valid  reply word handshake, o_tx_ready = holding reg empty
//   o_d_in, o_d_valid     last received word and its 1-cycle update pulse
//   o_busy                frame in progress
//   o_tx_underrun         1-cycle pulse: word started with an empty holding reg
//   o_frame_err           1-cycle pulse: CS rose mid-word
module spi_slave_bus #(
  parameter int                   BUS_WIDTH = 16,
  parameter int                   CNT_SIZE  = 4,
  parameter logic [BUS_WIDTH-1:0] TX_IDLE   = 16'hFFFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sclk,
  input  logic                 i_cs,
  input  logic                 i_si,
  output logic                 o_so,
  input  logic [BUS_WIDTH-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic [BUS_WIDTH-1:0] o_d_in,
  output logic                 o_d_valid,
  output logic                 o_busy,
  output logic                 o_tx_underrun,
  output logic                 o_frame_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam logic [CNT_SIZE-1:0] LAST_BIT = CNT_SIZE'(BUS_WIDTH - 1);
  localparam logic [CNT_SIZE-1:0] CNT_ZERO = {CNT_SIZE{1'b0}};
  localparam logic [CNT_SIZE-1:0] CNT_ONE  = CNT_SIZE'(1);

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_sclk_sync, r_cs_sync;
  logic [1:0]           r_si_sync;
  logic [BUS_WIDTH-1:0] r_rx_shift, w_rx_shift_nxt;
  logic [BUS_WIDTH-1:0] r_tx_shift, w_tx_shift_nxt;
  logic [BUS_WIDTH-1:0] r_hold, w_hold_nxt;
  logic [CNT_SIZE-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic                 r_skip_fall, w_skip_fall_nxt;
  logic                 r_so, w_so_nxt;
  logic                 r_tx_ready, w_tx_ready_nxt;
  logic [BUS_WIDTH-1:0] r_d_in, w_d_in_nxt;
  logic                 r_d_valid, w_d_valid_nxt;
  logic                 r_busy;
  logic                 r_tx_underrun, w_tx_underrun_nxt;
  logic                 r_frame_err, w_frame_err_nxt;

  logic                 w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_si;
  logic                 w_word_done, w_load, w_tx_write;
  logic [BUS_WIDTH-1:0] w_load_word;

  // Edges come from stages 2/3; SI uses stage 2 so it lines up with the SCLK edge.
  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
  assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
  assign w_si        = r_si_sync[1];

  // A word completes on the SCLK rise that carries its last bit (CS rise wins).
  assign w_word_done = (r_state == ST_SHIFT) & ~w_cs_rise & w_sclk_rise & (r_bit_cnt == LAST_BIT);
  assign w_load      = (r_state == ST_LOAD) | w_word_done;
  assign w_load_word = r_tx_ready ? TX_IDLE : r_hold;
  assign w_tx_write  = i_tx_valid & r_tx_ready;

  // Input synchronisers; CS resets high so no spurious frame start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sclk_sync <= 3'b000;
      r_cs_sync   <= 3'b111;
      r_si_sync   <= 2'b00;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
      r_cs_sync   <= {r_cs_sync[1:0], i_cs};
      r_si_sync   <= {r_si_sync[0], i_si};
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = w_cs_fall ? ST_LOAD : ST_IDLE;
      ST_LOAD:  w_state_nxt = w_cs_rise ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: w_state_nxt = w_cs_rise ? ST_IDLE : ST_SHIFT;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output / datapath next values.
  always_comb begin
    w_rx_shift_nxt    = r_rx_shift;
    w_tx_shift_nxt    = r_tx_shift;
    w_hold_nxt        = r_hold;
    w_tx_ready_nxt    = r_tx_ready;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_skip_fall_nxt   = r_skip_fall;
    w_so_nxt          = r_so;
    w_d_in_nxt        = r_d_in;
    w_d_valid_nxt     = 1'b0;
    w_tx_underrun_nxt = 1'b0;
    w_frame_err_nxt   = 1'b0;

    // Holding register: a load empties a full register; a write is only taken
    // while the register is empty, even in the cycle of a load.
    if (w_load) begin
      w_tx_shift_nxt = w_load_word;
      if (r_tx_ready) begin
        w_tx_underrun_nxt = 1'b1;
        if (w_tx_write) begin
          w_hold_nxt     = i_tx_data;
          w_tx_ready_nxt = 1'b0;
        end else begin
          w_tx_ready_nxt = 1'b1;
        end
      end else begin
        w_tx_ready_nxt = 1'b1;
      end
    end else if (w_tx_write) begin
      w_hold_nxt     = i_tx_data;
      w_tx_ready_nxt = 1'b0;
    end else begin
      w_tx_ready_nxt = r_tx_ready;
    end

    case (r_state)
      ST_IDLE: begin
        w_so_nxt        = 1'b1;
        w_bit_cnt_nxt   = CNT_ZERO;
        w_skip_fall_nxt = 1'b0;
      end
      ST_LOAD: begin
        w_bit_cnt_nxt   = CNT_ZERO;
        w_skip_fall_nxt = 1'b0;
        w_so_nxt        = w_cs_rise ? 1'b1 : w_load_word[BUS_WIDTH-1];
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          w_frame_err_nxt = (r_bit_cnt != CNT_ZERO);
          w_so_nxt        = 1'b1;
          w_bit_cnt_nxt   = CNT_ZERO;
          w_skip_fall_nxt = 1'b0;
        end else if (w_sclk_rise) begin
          w_rx_shift_nxt = {r_rx_shift[BUS_WIDTH-2:0], w_si};
          if (w_word_done) begin
            w_d_in_nxt      = {r_rx_shift[BUS_WIDTH-2:0], w_si};
            w_d_valid_nxt   = 1'b1;
            w_bit_cnt_nxt   = CNT_ZERO;
            w_so_nxt        = w_load_word[BUS_WIDTH-1];
            // SO already holds the new MSB; the next fall must not shift it away.
            w_skip_fall_nxt = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_ONE;
          end
        end else if (w_sclk_fall) begin
          if (r_skip_fall) begin
            w_skip_fall_nxt = 1'b0;
          end else begin
            w_tx_shift_nxt = {r_tx_shift[BUS_WIDTH-2:0], 1'b0};
            w_so_nxt       = r_tx_shift[BUS_WIDTH-2];
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt;
        end
      end
      default: begin
        w_so_nxt = 1'b1;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_shift    <= {BUS_WIDTH{1'b0}};
      r_tx_shift    <= {BUS_WIDTH{1'b0}};
      r_hold        <= {BUS_WIDTH{1'b0}};
      r_tx_ready    <= 1'b1;
      r_bit_cnt     <= CNT_ZERO;
      r_skip_fall   <= 1'b0;
      r_so          <= 1'b1;
      r_d_in        <= {BUS_WIDTH{1'b0}};
      r_d_valid     <= 1'b0;
      r_busy        <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_rx_shift    <= w_rx_shift_nxt;
      r_tx_shift    <= w_tx_shift_nxt;
      r_hold        <= w_hold_nxt;
      r_tx_ready    <= w_tx_ready_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_skip_fall   <= w_skip_fall_nxt;
      r_so          <= w_so_nxt;
      r_d_in        <= w_d_in_nxt;
      r_d_valid     <= w_d_valid_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_tx_underrun <= w_tx_underrun_nxt;
      r_frame_err   <= w_frame_err_nxt;
    end
  end

  assign o_so          = r_so;
  assign o_tx_ready    = r_tx_ready;
  assign o_d_in        = r_d_in;
  assign o_d_valid     = r_d_valid;
  assign o_busy        = r_busy;
  assign o_tx_underrun = r_tx_underrun;
  assign o_frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_slave_bus.sv
// Self-checking bench for spi_slave_bus: table of single-word frames plus
// hand-written sequences for back-to-back words, partial frames, reset
// mid-frame and SCLK activity with CS high. Received words are checked
// through a scoreboard queue filled when a full word is driven.
module tb_spi_slave_bus;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_sclk = 1'b0;
  logic        i_cs = 1'b1;
  logic        i_si = 1'b0;
  logic        o_so;
  logic [15:0] i_tx_data = 16'h0000;
  logic        i_tx_valid = 1'b0;
  logic        o_tx_ready;
  logic [15:0] o_d_in;
  logic        o_d_valid;
  logic        o_busy;
  logic        o_tx_underrun;
  logic        o_frame_err;

  spi_slave_bus dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sclk(i_sclk), .i_cs(i_cs), .i_si(i_si),
    .o_so(o_so), .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid),
    .o_tx_ready(o_tx_ready), .o_d_in(o_d_in), .o_d_valid(o_d_valid),
    .o_busy(o_busy), .o_tx_underrun(o_tx_underrun), .o_frame_err(o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  int n_dvalid = 0;
  int n_ferr = 0;
  int n_under = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pulse monitor and scoreboard, sampled on the falling clock edge.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_d_valid) begin
        n_dvalid++;
        if (exp_q.size() == 0) chk("unexpected d_valid", 32'd1, 32'd0);
        else chk("d_in", {16'h0, o_d_in}, {16'h0, exp_q.pop_front()});
      end
      if (o_frame_err) n_ferr++;
      if (o_tx_underrun) n_under++;
      if (o_d_valid || o_frame_err) chk("d_valid with frame_err", {31'h0, o_d_valid & o_frame_err}, 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic write_tx(input logic [15:0] d);
    int n;
    n = 0;
    @(negedge i_clk);
    i_tx_data  = d;
    i_tx_valid = 1'b1;
    while (!o_tx_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    chk("tx_ready wait", {31'h0, o_tx_ready}, 32'd1);
    @(negedge i_clk);
    i_tx_valid = 1'b0;
  endtask

  task automatic spi_bits(input logic [15:0] mosi, input int nbits, output logic [15:0] miso);
    miso = 16'h0000;
    for (int i = 0; i < nbits; i++) begin
      i_si = mosi[15-i];
      repeat (4) @(negedge i_clk);
      miso[15-i] = o_so;
      i_sclk = 1'b1;
      repeat (4) @(negedge i_clk);
      i_sclk = 1'b0;
    end
  endtask

  task automatic spi_word(input logic [15:0] mosi, output logic [15:0] miso);
    exp_q.push_back(mosi);
    spi_bits(mosi, 16, miso);
  endtask

  task automatic frame_start(input logic exp_under);
    int u0;
    u0 = n_under;
    @(negedge i_clk);
    i_cs = 1'b0;
    repeat (8) @(negedge i_clk);
    chk("underrun at load", n_under - u0, {31'h0, exp_under});
    chk("busy in frame", {31'h0, o_busy}, 32'd1);
  endtask

  task automatic frame_end();
    repeat (4) @(negedge i_clk);
    i_cs = 1'b1;
    repeat (8) @(negedge i_clk);
    chk("busy after frame", {31'h0, o_busy}, 32'd0);
    chk("so after frame", {31'h0, o_so}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] tx;
    logic        load_tx;
    logic [15:0] mosi;
    logic [15:0] exp_miso;
    logic        exp_under;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [15:0] m1, m2;
    int d0, f0;

    vecs[0] = '{tx: 16'hA55A, load_tx: 1'b1, mosi: 16'h1234, exp_miso: 16'hA55A, exp_under: 1'b0};
    vecs[1] = '{tx: 16'h0000, load_tx: 1'b0, mosi: 16'h00FF, exp_miso: 16'hFFFF, exp_under: 1'b1};
    vecs[2] = '{tx: 16'h0000, load_tx: 1'b1, mosi: 16'hFFFF, exp_miso: 16'h0000, exp_under: 1'b0};
    vecs[3] = '{tx: 16'h8421, load_tx: 1'b1, mosi: 16'h5AA5, exp_miso: 16'h8421, exp_under: 1'b0};
    vecs[4] = '{tx: 16'h0000, load_tx: 1'b0, mosi: 16'h0001, exp_miso: 16'hFFFF, exp_under: 1'b1};

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("rst so", {31'h0, o_so}, 32'd1);
    chk("rst tx_ready", {31'h0, o_tx_ready}, 32'd1);
    chk("rst d_in", {16'h0, o_d_in}, 32'd0);
    chk("rst pulses", {29'h0, o_d_valid, o_tx_underrun, o_frame_err}, 32'd0);
    chk("rst busy", {31'h0, o_busy}, 32'd0);
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);

    // Single-word frames from the table
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].load_tx) begin
        write_tx(vecs[v].tx);
        chk("tx_ready after write", {31'h0, o_tx_ready}, 32'd0);
      end
      d0 = n_dvalid;
      frame_start(vecs[v].exp_under);
      spi_word(vecs[v].mosi, m1);
      frame_end();
      chk("miso word", {16'h0, m1}, {16'h0, vecs[v].exp_miso});
      chk("d_valid count", n_dvalid - d0, 32'd1);
      chk("d_in after frame", {16'h0, o_d_in}, {16'h0, vecs[v].mosi});
    end

    // Two back-to-back words, second reply written during the first word
    write_tx(16'h1111);
    d0 = n_dvalid;
    frame_start(1'b0);
    fork
      spi_word(16'h8001, m1);
      begin
        repeat (30) @(negedge i_clk);
        write_tx(16'h2222);
      end
    join
    spi_word(16'h7FFE, m2);
    frame_end();
    chk("b2b miso 1", {16'h0, m1}, 32'h1111);
    chk("b2b miso 2", {16'h0, m2}, 32'h2222);
    chk("b2b d_valid count", n_dvalid - d0, 32'd2);
    chk("b2b d_in", {16'h0, o_d_in}, 32'h7FFE);

    // Partial frame: 9 bits then CS high
    d0 = n_dvalid;
    f0 = n_ferr;
    frame_start(1'b1);
    spi_bits(16'hC3C3, 9, m1);
    frame_end();
    chk("partial frame_err count", n_ferr - f0, 32'd1);
    chk("partial d_valid count", n_dvalid - d0, 32'd0);
    chk("partial d_in kept", {16'h0, o_d_in}, 32'h7FFE);

    // Reset at bit 7 with a word waiting in the holding register
    d0 = n_dvalid;
    frame_start(1'b1);
    spi_bits(16'hDEAD, 7, m1);
    write_tx(16'h5555);
    chk("hold full before rst", {31'h0, o_tx_ready}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    i_cs  = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("midrst so", {31'h0, o_so}, 32'd1);
    chk("midrst tx_ready", {31'h0, o_tx_ready}, 32'd1);
    chk("midrst d_in", {16'h0, o_d_in}, 32'd0);
    chk("midrst busy", {31'h0, o_busy}, 32'd0);
    i_rst = 1'b0;
    repeat (8) @(negedge i_clk);
    chk("after rst busy", {31'h0, o_busy}, 32'd0);
    chk("after rst no pulses", n_dvalid - d0, 32'd0);
    frame_start(1'b1);
    spi_word(16'hBEEF, m1);
    frame_end();
    chk("post-rst miso", {16'h0, m1}, 32'hFFFF);
    chk("post-rst d_in", {16'h0, o_d_in}, 32'hBEEF);

    // SCLK activity with CS high is ignored
    d0 = n_dvalid;
    f0 = n_ferr;
    for (int k = 0; k < 20; k++) begin
      i_si = k[0];
      repeat (4) @(negedge i_clk);
      i_sclk = ~i_sclk;
      if (o_so !== 1'b1 || o_busy !== 1'b0) chk("cs-high so/busy", {30'h0, o_so, o_busy}, 32'd2);
    end
    i_sclk = 1'b0;
    repeat (8) @(negedge i_clk);
    chk("cs-high so", {31'h0, o_so}, 32'd1);
    chk("cs-high busy", {31'h0, o_busy}, 32'd0);
    chk("cs-high pulses", (n_dvalid - d0) + (n_ferr - f0), 32'd0);
    chk("cs-high d_in", {16'h0, o_d_in}, 32'hBEEF);

    chk("scoreboard empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
